fmrv32im_lsu: RTL and testbench

- Load/store unit directly downstream of the integer ALU.
- Consumes the ALU's registered effective address (RS1+IMM) for LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives the data-memory bus with byte strobes and lane-replicated store data.
- Returns aligned, sign- or zero-extended load data to writeback. Signals completion to the pipeline controller with a one-cycle pulse.

---
 rtl/fmrv32im_pkg.sv | 83 ++++++++
 rtl/fmrv32im_lsu_align.sv | 56 +++++
 rtl/fmrv32im_lsu.sv | 140 ++++++++++++++
 tb/tb_fmrv32im_lsu.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmrv32im_pkg.sv
// Shared LSU types: FSM states, access sizes, strobe constants.
// Also holds the one-hot instruction decoder and alignment check.
package fmrv32im_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } lsu_size_e;

  localparam logic [3:0] WSTB_NONE = 4'b0000;
  localparam logic [3:0] WSTB_WORD = 4'b1111;

  typedef struct packed {
    lsu_size_e size;
    logic      store;
    logic      uns;
  } lsu_req_t;

  function automatic lsu_req_t lsu_decode(
    input logic lb,
    input logic lh,
    input logic lw,
    input logic lbu,
    input logic lhu,
    input logic sb,
    input logic sh,
    input logic sw
  );
    lsu_req_t r;
    r.size  = SZ_WORD;
    r.store = 1'b0;
    r.uns   = 1'b0;
    unique case (1'b1)
      lb:  r.size = SZ_BYTE;
      lh:  r.size = SZ_HALF;
      lw:  r.size = SZ_WORD;
      lbu: begin
        r.size = SZ_BYTE;
        r.uns  = 1'b1;
      end
      lhu: begin
        r.size = SZ_HALF;
        r.uns  = 1'b1;
      end
      sb: begin
        r.size  = SZ_BYTE;
        r.store = 1'b1;
      end
      sh: begin
        r.size  = SZ_HALF;
        r.store = 1'b1;
      end
      sw: begin
        r.size  = SZ_WORD;
        r.store = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic lsu_misaligned(
    input lsu_size_e  s,
    input logic [1:0] lo
  );
    logic m;
    m = 1'b0;
    unique case (s)
      SZ_HALF: m = lo[0];
      SZ_WORD: m = |lo;
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/fmrv32im_lsu_align.sv
// Combinational lane logic: store replication/strobes, load extract.
// Ports: st_* = store request in, lanes out; ld_* = bus word in, result out.
module fmrv32im_lsu_align
  import fmrv32im_pkg::*;
(
  input  lsu_size_e   st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_data,
  output logic [3:0]  st_wstb,
  output logic [31:0] st_wdata,
  input  lsu_size_e   ld_size,
  input  logic        ld_uns,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] ld_data,
  output logic [31:0] ld_rslt
);

  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    st_wstb  = WSTB_WORD;
    st_wdata = st_data;
    unique case (st_size)
      SZ_BYTE: begin
        st_wdata = {4{st_data[7:0]}};
        st_wstb  = 4'b0001 << st_lane;
      end
      SZ_HALF: begin
        st_wdata = {2{st_data[15:0]}};
        st_wstb  = st_lane[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_b = ld_data[7:0];
    unique case (ld_lane)
      2'd0: ld_b = ld_data[7:0];
      2'd1: ld_b = ld_data[15:8];
      2'd2: ld_b = ld_data[23:16];
      2'd3: ld_b = ld_data[31:24];
      default: ;
    endcase
    ld_h = ld_lane[1] ? ld_data[31:16]
                      : ld_data[15:0];
    ld_rslt = ld_data;
    unique case (ld_size)
      SZ_BYTE: ld_rslt = {{24{ld_b[7] & ~ld_uns}}, ld_b};
      SZ_HALF: ld_rslt = {{16{ld_h[15] & ~ld_uns}}, ld_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/fmrv32im_lsu.sv
// Load/store unit: IDLE/ACCESS/DONE FSM, bus wait + timeout, result pulse.
// Ports: ADDR_VALID/ADDR/INST_*/WDATA in; BUS_* data bus; LSU_* to pipeline.
// Macro FMRV32IM_LSU_MISALIGN_EN: trap misaligned accesses via LSU_EXC.
module fmrv32im_lsu
  import fmrv32im_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic        RST_N,
  input  logic        CLK,
  input  logic        ADDR_VALID,
  input  logic [31:0] ADDR,
  input  logic        INST_LB,
  input  logic        INST_LH,
  input  logic        INST_LW,
  input  logic        INST_LBU,
  input  logic        INST_LHU,
  input  logic        INST_SB,
  input  logic        INST_SH,
  input  logic        INST_SW,
  input  logic [31:0] WDATA,
  output logic        BUS_ENA,
  output logic [3:0]  BUS_WSTB,
  output logic [31:0] BUS_ADDR,
  output logic [31:0] BUS_WDATA,
  input  logic        BUS_WAIT,
  input  logic [31:0] BUS_RDATA,
  output logic        LSU_BUSY,
  output logic        LSU_DONE,
  output logic [31:0] LSU_RDATA,
  output logic        LSU_ERR,
  output logic        LSU_EXC
);

  localparam logic [31:0] TMO = 32'(TIMEOUT);

  lsu_state_e  state;
  lsu_req_t    req_q;
  logic [1:0]  lane_q;
  logic [31:0] tmo_cnt;
  logic        exc_q;

  lsu_req_t    dec;
  logic [3:0]  st_wstb;
  logic [31:0] st_wdata;
  logic [31:0] ld_rslt;

  assign dec = lsu_decode(INST_LB, INST_LH, INST_LW,
                          INST_LBU, INST_LHU,
                          INST_SB, INST_SH, INST_SW);

  fmrv32im_lsu_align u_align (
    .st_size  (dec.size),
    .st_lane  (ADDR[1:0]),
    .st_data  (WDATA),
    .st_wstb  (st_wstb),
    .st_wdata (st_wdata),
    .ld_size  (req_q.size),
    .ld_uns   (req_q.uns),
    .ld_lane  (lane_q),
    .ld_data  (BUS_RDATA),
    .ld_rslt  (ld_rslt)
  );

  assign LSU_EXC = exc_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      lane_q    <= 2'd0;
      tmo_cnt   <= '0;
      exc_q     <= 1'b0;
      BUS_ENA   <= 1'b0;
      BUS_WSTB  <= WSTB_NONE;
      BUS_ADDR  <= '0;
      BUS_WDATA <= '0;
      LSU_BUSY  <= 1'b0;
      LSU_DONE  <= 1'b0;
      LSU_RDATA <= '0;
      LSU_ERR   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          LSU_DONE <= 1'b0;
          LSU_ERR  <= 1'b0;
          exc_q    <= 1'b0;
          if (ADDR_VALID) begin
            req_q  <= dec;
            lane_q <= ADDR[1:0];
`ifdef FMRV32IM_LSU_MISALIGN_EN
            if (lsu_misaligned(dec.size, ADDR[1:0])) begin
              // Trap without touching the bus.
              state     <= ST_DONE;
              LSU_DONE  <= 1'b1;
              exc_q     <= 1'b1;
              LSU_RDATA <= '0;
            end else begin
`else
            begin
`endif
              state     <= ST_ACCESS;
              tmo_cnt   <= '0;
              BUS_ENA   <= 1'b1;
              BUS_ADDR  <= {ADDR[31:2], 2'b00};
              BUS_WSTB  <= dec.store ? st_wstb : WSTB_NONE;
              BUS_WDATA <= dec.store ? st_wdata : '0;
              LSU_BUSY  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (!BUS_WAIT) begin
            state     <= ST_DONE;
            BUS_ENA   <= 1'b0;
            BUS_WSTB  <= WSTB_NONE;
            LSU_BUSY  <= 1'b0;
            LSU_DONE  <= 1'b1;
            LSU_RDATA <= req_q.store ? '0 : ld_rslt;
          end else if (TIMEOUT > 0) begin
            tmo_cnt <= tmo_cnt + 32'd1;
            if (tmo_cnt + 32'd1 == TMO) begin
              state     <= ST_DONE;
              BUS_ENA   <= 1'b0;
              BUS_WSTB  <= WSTB_NONE;
              LSU_BUSY  <= 1'b0;
              LSU_DONE  <= 1'b1;
              LSU_ERR   <= 1'b1;
              LSU_RDATA <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmrv32im_lsu.sv
// Self-checking bench for fmrv32im_lsu: bus slave, access model, monitor.
// Directed vectors plus hand-computed literal results.
module tb_fmrv32im_lsu;

  localparam int TMO = 4;
  localparam int K_LB = 0, K_LH = 1, K_LW = 2, K_LBU = 3;
  localparam int K_LHU = 4, K_SB = 5, K_SH = 6, K_SW = 7;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ADDR_VALID = 1'b0;
  logic [31:0] ADDR = '0;
  logic [7:0]  inst = '0;
  logic [31:0] WDATA = '0;
  logic        BUS_ENA;
  logic [3:0]  BUS_WSTB;
  logic [31:0] BUS_ADDR;
  logic [31:0] BUS_WDATA;
  logic        BUS_WAIT;
  logic [31:0] BUS_RDATA = '0;
  logic        LSU_BUSY;
  logic        LSU_DONE;
  logic [31:0] LSU_RDATA;
  logic        LSU_ERR;
  logic        LSU_EXC;

  fmrv32im_lsu #(.TIMEOUT(TMO)) dut (
    .RST_N      (RST_N),
    .CLK        (CLK),
    .ADDR_VALID (ADDR_VALID),
    .ADDR       (ADDR),
    .INST_LB    (inst[K_LB]),
    .INST_LH    (inst[K_LH]),
    .INST_LW    (inst[K_LW]),
    .INST_LBU   (inst[K_LBU]),
    .INST_LHU   (inst[K_LHU]),
    .INST_SB    (inst[K_SB]),
    .INST_SH    (inst[K_SH]),
    .INST_SW    (inst[K_SW]),
    .WDATA      (WDATA),
    .BUS_ENA    (BUS_ENA),
    .BUS_WSTB   (BUS_WSTB),
    .BUS_ADDR   (BUS_ADDR),
    .BUS_WDATA  (BUS_WDATA),
    .BUS_WAIT   (BUS_WAIT),
    .BUS_RDATA  (BUS_RDATA),
    .LSU_BUSY   (LSU_BUSY),
    .LSU_DONE   (LSU_DONE),
    .LSU_RDATA  (LSU_RDATA),
    .LSU_ERR    (LSU_ERR),
    .LSU_EXC    (LSU_EXC)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Bus slave: stall the first wait_cfg cycles of each request.
  int wait_cfg = 0;
  int ena_cnt = 0;
  always @(posedge CLK)
    ena_cnt <= (BUS_ENA && BUS_WAIT) ? ena_cnt + 1 : 0;
  assign BUS_WAIT = BUS_ENA && (ena_cnt < wait_cfg);

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] bus;
    int          done;
    logic        err;
    logic        exc;
  } txn_t;
  txn_t q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0d", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_store(input int k);
    return k >= K_SB;
  endfunction

  function automatic int m_bytes(input int k);
    if (k == K_LB || k == K_LBU || k == K_SB) return 1;
    if (k == K_LH || k == K_LHU || k == K_SH) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_wstb(input int k, input logic [31:0] a);
    int n;
    if (!m_store(k)) return 4'h0;
    n = m_bytes(k);
    // n consecutive strobes starting at the byte offset within the word
    return 4'(((1 << n) - 1) << (a % 4 / n * n));
  endfunction

  function automatic logic [31:0] m_wdata(input int k, input logic [31:0] w);
    if (k == K_SB) return (w & 32'hFF) * 32'h01010101;
    if (k == K_SH) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int k, input logic [31:0] a,
                                         input logic [31:0] bus);
    logic [31:0] v;
    int bits;
    if (m_store(k)) return 32'h0;
    if (k == K_LW) return bus;
    bits = 8 * m_bytes(k);
    v = bus >> (bits * ((a % 4) / m_bytes(k)));
    v = v & ((32'd1 << bits) - 32'd1);
    if ((k == K_LB || k == K_LH) && v >= (32'd1 << (bits - 1)))
      v = v - (32'd1 << bits);
    return v;
  endfunction

  function automatic bit m_misal(input int k, input logic [31:0] a);
`ifdef FMRV32IM_LSU_MISALIGN_EN
    return (a % m_bytes(k)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  logic [31:0] last_rdata;
  logic        last_err, last_exc, last_ena_at_done;
  logic [31:0] last_baddr, last_bwdata;
  logic [3:0]  last_bwstb;
  int          last_done = 0;
  int          ena_start = 0;
  logic        ena_prev = 1'b0;

  // Compare process: bus side while requesting, result side on DONE.
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("busy_eq_ena", {31'b0, LSU_BUSY}, {31'b0, BUS_ENA});
      if (BUS_ENA) begin
        if (!ena_prev) ena_start = cyc;
        last_baddr  = BUS_ADDR;
        last_bwstb  = BUS_WSTB;
        last_bwdata = BUS_WDATA;
        if (q.size() == 0) begin
          chk("ena_unexpected", {31'b0, BUS_ENA}, 32'h0);
        end else if (q[0].exc) begin
          chk("ena_on_misal", {31'b0, BUS_ENA}, 32'h0);
        end else begin
          chk("bus_addr", BUS_ADDR, q[0].a & 32'hFFFFFFFC);
          chk("bus_wstb", {28'b0, BUS_WSTB}, {28'b0, m_wstb(q[0].k, q[0].a)});
          if (m_store(q[0].k))
            chk("bus_wdata", BUS_WDATA, m_wdata(q[0].k, q[0].w));
        end
      end
      if (LSU_DONE) begin
        last_rdata = LSU_RDATA;
        last_err = LSU_ERR;
        last_exc = LSU_EXC;
        last_ena_at_done = BUS_ENA;
        last_done = cyc;
        if (q.size() == 0) begin
          chk("done_unexpected", {31'b0, LSU_DONE}, 32'h0);
        end else begin
          chk("done_cycle", 32'(cyc), 32'(q[0].done));
          chk("lsu_err", {31'b0, LSU_ERR}, {31'b0, q[0].err});
          chk("lsu_exc", {31'b0, LSU_EXC}, {31'b0, q[0].exc});
          chk("lsu_rdata", LSU_RDATA,
              (q[0].err || q[0].exc) ? 32'h0 : m_load(q[0].k, q[0].a, q[0].bus));
          void'(q.pop_front());
        end
      end
      ena_prev = BUS_ENA;
    end else begin
      ena_prev = 1'b0;
    end
  end

  always @(posedge CLK)
    if (RST_N && ADDR_VALID && LSU_BUSY) begin
      failures++;
      $display("FAIL addr_valid_in_access t=%0d", cyc);
    end

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] w,
                       input logic [31:0] bus, input int waits, output int n);
    txn_t t;
    t.k = k; t.a = a; t.w = w; t.bus = bus;
    t.exc = m_misal(k, a);
    t.err = 1'b0;
    if (t.exc) t.done = cyc + 1;
    else if (waits >= TMO) begin
      t.done = cyc + 1 + TMO;
      t.err = 1'b1;
    end else t.done = cyc + 2 + waits;
    q.push_back(t);
    wait_cfg = waits;
    BUS_RDATA = bus;
    ADDR = a;
    WDATA = w;
    inst = 8'(1 << k);
    ADDR_VALID = 1'b1;
    n = cyc;
    @(posedge CLK); #1;
    ADDR_VALID = 1'b0;
    inst = '0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(posedge CLK); #1;
    end
    if (q.size() != 0) begin
      chk("wait_timeout", 32'(q.size()), 32'h0);
      q.delete();
    end
    @(posedge CLK); #1;
  endtask

  int n, n1;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_outs",
        {BUS_ENA, BUS_WSTB, LSU_BUSY, LSU_DONE, LSU_ERR, LSU_EXC},
        32'h0);
    chk("rst_data", BUS_ADDR | BUS_WDATA | LSU_RDATA, 32'h0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    issue(K_SB, 32'h1003, 32'h000000A5, 32'h0, 0, n);
    wait_idle();
    chk("sb_addr", last_baddr, 32'h00001000);
    chk("sb_wstb", {28'b0, last_bwstb}, 32'h8);
    chk("sb_wdata", last_bwdata, 32'hA5A5A5A5);
    chk("sb_lat", 32'(last_done - n), 32'd2);
    chk("sb_rdata", last_rdata, 32'h0);

    issue(K_LB, 32'h2002, 32'h0, 32'h1280FF34, 0, n);
    wait_idle();
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    issue(K_LBU, 32'h2002, 32'h0, 32'h1280FF34, 0, n);
    wait_idle();
    chk("lbu_rdata", last_rdata, 32'h00000080);
    issue(K_LHU, 32'h2002, 32'h0, 32'h1280FF34, 0, n);
    wait_idle();
    chk("lhu_rdata", last_rdata, 32'h00001280);
    issue(K_LH, 32'h2000, 32'h0, 32'h1280FF34, 1, n);
    wait_idle();
    chk("lh_rdata", last_rdata, 32'hFFFFFF34);

    issue(K_LW, 32'h3000, 32'h0, 32'hCAFEF00D, 3, n);
    wait_idle();
    chk("lw_wait_lat", 32'(last_done - n), 32'd5);
    chk("lw_wait_rdata", last_rdata, 32'hCAFEF00D);

    issue(K_SH, 32'h3002, 32'hDEADBEEF, 32'h0, 0, n);
    wait_idle();
    chk("sh_wstb", {28'b0, last_bwstb}, 32'hC);
    chk("sh_wdata", last_bwdata, 32'hBEEFBEEF);
    issue(K_SB, 32'h3001, 32'h12345677, 32'h0, 2, n);
    wait_idle();
    chk("sb1_wstb", {28'b0, last_bwstb}, 32'h2);

    issue(K_SW, 32'h4000, 32'h11223344, 32'h0, 0, n1);
    for (int i = 0; i < 20 && !LSU_DONE; i++) begin
      @(posedge CLK); #1;
    end
    issue(K_LH, 32'h4006, 32'h0, 32'h80010000, 0, n);
    wait_idle();
    chk("b2b_ena", 32'(ena_start - n1), 32'd3);
    chk("b2b_lat", 32'(last_done - n1), 32'd4);
    chk("b2b_rdata", last_rdata, 32'hFFFF8001);

    issue(K_LW, 32'h5002, 32'h0, 32'h89ABCDEF, 0, n);
    wait_idle();
`ifdef FMRV32IM_LSU_MISALIGN_EN
    chk("mis_lat", 32'(last_done - n), 32'd1);
    chk("mis_exc", {31'b0, last_exc}, 32'd1);
`else
    chk("mis_addr", last_baddr, 32'h00005000);
    chk("mis_rdata", last_rdata, 32'h89ABCDEF);
`endif

    issue(K_LW, 32'h6000, 32'h0, 32'h55555555, 100, n);
    wait_idle();
    chk("tmo_lat", 32'(last_done - n), 32'd5);
    chk("tmo_err", {31'b0, last_err}, 32'd1);
    chk("tmo_ena", {31'b0, last_ena_at_done}, 32'd0);
    chk("tmo_rdata", last_rdata, 32'h0);

    issue(K_SW, 32'h7000, 32'hA5A55A5A, 32'h0, 100, n);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(negedge CLK);
    chk("pre_rst_ena", {31'b0, BUS_ENA}, 32'd1);
    @(posedge CLK); #1;
    chk("mid_rst_outs",
        {BUS_ENA, BUS_WSTB, LSU_BUSY, LSU_DONE, LSU_ERR, LSU_EXC},
        32'h0);
    chk("mid_rst_data", BUS_ADDR | BUS_WDATA | LSU_RDATA, 32'h0);
    q.delete();
    wait_cfg = 0;
    RST_N = 1'b1;
    repeat (8) @(posedge CLK);
    #1;
    chk("post_rst_idle", {30'b0, LSU_DONE, BUS_ENA}, 32'h0);

    issue(K_LBU, 32'h8001, 32'h0, 32'h0000C300, 0, n);
    wait_idle();
    chk("recover_rdata", last_rdata, 32'h000000C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
